memory_unit: RTL and testbench

- Word-addressed memory responder sitting at the far end of the processor's address path.
- Address register output drives `address`; Bus_1 drives `data_in`; `data_out` returns to the bus mux.
- The controller issues a request; the block serves it after a parameterised number of wait states and pulses `ready`.
- The FSM is sequenced by the processor controller's request/ready handshake.

---
 rtl/memory_unit_if.sv | 32 +++
 rtl/memory_unit.sv | 98 +++++++++
 tb/tb_memory_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_unit_if.sv
// Request/response bundle between the processor controller and memory_unit.
// MEM_RANGE_ERR_EN adds the out-of-range error strobe.
interface memory_unit_if #(
    parameter int word_size = 8
);
    logic [word_size-1:0] address;
    logic [word_size-1:0] data_in;
    logic [word_size-1:0] data_out;
    logic                 write;
    logic                 req;
    logic                 ready;
    logic                 busy;
`ifdef MEM_RANGE_ERR_EN
    logic                 error;
`endif

    modport master (
        output address, data_in, write, req,
        input  data_out, ready, busy
`ifdef MEM_RANGE_ERR_EN
        , input error
`endif
    );

    modport slave (
        input  address, data_in, write, req,
        output data_out, ready, busy
`ifdef MEM_RANGE_ERR_EN
        , output error
`endif
    );
endinterface

// File: rtl/memory_unit.sv
// Word-addressed memory responder with parameterised wait states.
// Optional MEM_RANGE_ERR_EN flags out-of-range accesses on bus.error.
module memory_unit #(
    parameter int word_size   = 8,
    parameter int memory_size = 256,
    parameter int wait_states = 2
) (
    input  logic         clk,
    input  logic         rst,
    memory_unit_if.slave bus
);
    localparam int AW = (memory_size > 1) ? $clog2(memory_size) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic [3:0]           cnt;
    logic [word_size-1:0] lat_addr;
    logic [word_size-1:0] lat_data;
    logic                 lat_write;
    logic [word_size-1:0] dout;
    logic                 rdy;
    logic                 bsy;
    logic                 in_range;
    logic [AW-1:0]        idx;
    logic [word_size-1:0] mem [memory_size];

    assign idx      = lat_addr[AW-1:0];
    assign in_range = 32'(lat_addr) < 32'(memory_size);

    assign bus.data_out = dout;
    assign bus.ready    = rdy;
    assign bus.busy     = bsy;

    // The ready cycle doubles as a turnaround: no acceptance while it is high.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req && !rdy) begin
                    accept   = 1'b1;
                    state_nx = (wait_states > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            dout      <= '0;
            rdy       <= 1'b0;
            bsy       <= 1'b0;
        end else begin
            state <= state_nx;
            rdy   <= (state == RESP);
            bsy   <= (state_nx != IDLE) || (state == RESP);
            if (accept) begin
                lat_addr  <= bus.address;
                lat_data  <= bus.data_in;
                lat_write <= bus.write;
                cnt       <= 4'(wait_states);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == RESP && !lat_write)
                dout <= in_range ? mem[idx] : '0;
        end
    end

    // Array has no reset; a reset drops state to IDLE so no commit follows.
    always_ff @(posedge clk) begin
        if (state == RESP && lat_write && in_range)
            mem[idx] <= lat_data;
    end

`ifdef MEM_RANGE_ERR_EN
    logic err;
    assign bus.error = err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else      err <= (state == RESP) && !in_range;
    end
`endif
endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: three instances cover wait_states=2,
// wait_states=0 and memory_size=128 (out-of-range).
module tb_memory_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    logic [7:0] addr_s [3];
    logic [7:0] din_s  [3];
    logic       wr_s   [3];
    logic       req_s  [3];
    logic [7:0] dout_s [3];
    logic       rdy_s  [3];
    logic       bsy_s  [3];
`ifdef MEM_RANGE_ERR_EN
    logic       err_s  [3];
`endif

    memory_unit_if #(.word_size(8)) i0 ();
    memory_unit_if #(.word_size(8)) i1 ();
    memory_unit_if #(.word_size(8)) i2 ();

    assign i0.address = addr_s[0]; assign i0.data_in = din_s[0];
    assign i0.write = wr_s[0];     assign i0.req = req_s[0];
    assign dout_s[0] = i0.data_out;
    assign rdy_s[0] = i0.ready;    assign bsy_s[0] = i0.busy;
    assign i1.address = addr_s[1]; assign i1.data_in = din_s[1];
    assign i1.write = wr_s[1];     assign i1.req = req_s[1];
    assign dout_s[1] = i1.data_out;
    assign rdy_s[1] = i1.ready;    assign bsy_s[1] = i1.busy;
    assign i2.address = addr_s[2]; assign i2.data_in = din_s[2];
    assign i2.write = wr_s[2];     assign i2.req = req_s[2];
    assign dout_s[2] = i2.data_out;
    assign rdy_s[2] = i2.ready;    assign bsy_s[2] = i2.busy;
`ifdef MEM_RANGE_ERR_EN
    assign err_s[0] = i0.error;
    assign err_s[1] = i1.error;
    assign err_s[2] = i2.error;
`endif

    memory_unit #(.word_size(8), .memory_size(256), .wait_states(2))
        u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    memory_unit #(.word_size(8), .memory_size(256), .wait_states(0))
        u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    memory_unit #(.word_size(8), .memory_size(128), .wait_states(2))
        u2 (.clk(clk), .rst(rst), .bus(i2.slave));

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        bit         err;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] ref_mem [3][256];

    function automatic int size_of(input int d);
        return (d == 2) ? 128 : 256;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    task automatic push_exp(input int d, input bit w,
                            input logic [7:0] a, input logic [7:0] wd);
        exp_t e;
        bit   oor;
        oor       = int'(a) >= size_of(d);
        e.is_read = !w;
        e.err     = oor;
        e.data    = (w || oor) ? 8'h00 : ref_mem[d][a];
        if (w && !oor) ref_mem[d][a] = wd;
        sb.push_back(e);
    endtask

    task automatic check_pop(input int d, input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++; fails++;
            $display("FAIL %s: ready with empty scoreboard", nm);
            return;
        end
        e = sb.pop_front();
        if (e.is_read) begin
            tests_run++;
            if (dout_s[d] !== e.data) begin
                fails++;
                $display("FAIL %s data_out: got %h want %h", nm, dout_s[d], e.data);
            end
        end
`ifdef MEM_RANGE_ERR_EN
        tests_run++;
        if (err_s[d] !== e.err) begin
            fails++;
            $display("FAIL %s error: got %b want %b", nm, err_s[d], e.err);
        end
`endif
    endtask

    // One full transaction; wiggle disturbs inputs (and re-asserts req) mid-access.
    task automatic access(input int d, input bit w, input logic [7:0] a,
                          input logic [7:0] wd, input bit wiggle,
                          input string nm);
        int n;
        push_exp(d, w, a, wd);
        @(negedge clk);
        req_s[d] = 1'b1; wr_s[d] = w; addr_s[d] = a; din_s[d] = wd;
        @(posedge clk); #1;
        req_s[d] = 1'b0;
        if (wiggle) begin
            req_s[d] = 1'b1; addr_s[d] = a + 8'd1;
            wr_s[d] = ~w; din_s[d] = 8'hEE;
        end
        n = 0;
        while (!rdy_s[d] && n < 40) begin
            tests_run++;
            if (bsy_s[d] !== 1'b1) begin
                fails++;
                $display("FAIL %s busy: got %b want 1 at cycle %0d", nm, bsy_s[d], n);
            end
            @(posedge clk); #1;
            n++;
        end
        req_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = a;
        tests_run++;
        if (!rdy_s[d]) begin
            fails++;
            $display("FAIL %s timeout: no ready after %0d cycles", nm, n);
            void'(sb.pop_front());
            return;
        end
        if (n != ws_of(d) + 1) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", nm, n, ws_of(d) + 1);
        end
        check_pop(d, nm);
        tests_run++;
        if (bsy_s[d] !== 1'b1) begin
            fails++;
            $display("FAIL %s busy in ready cycle: got %b want 1", nm, bsy_s[d]);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rdy_s[d] !== 1'b0 || bsy_s[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s after done: ready %b busy %b want 0 0",
                     nm, rdy_s[d], bsy_s[d]);
        end
    endtask

    task automatic test_reset;
        #12;
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (dout_s[d] !== 8'h00 || rdy_s[d] !== 1'b0 || bsy_s[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset dut%0d: dout %h ready %b busy %b want 00 0 0",
                         d, dout_s[d], rdy_s[d], bsy_s[d]);
            end
`ifdef MEM_RANGE_ERR_EN
            tests_run++;
            if (err_s[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset error dut%0d: got %b want 0", d, err_s[d]);
            end
`endif
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        access(0, 1'b1, 8'h05, 8'h3C, 1'b0, "wr_05");
        access(0, 1'b0, 8'h05, 8'h00, 1'b0, "rd_05");
    endtask

    task automatic test_abort_reset;
        access(0, 1'b1, 8'h10, 8'h55, 1'b0, "pre_wr_10");
        access(0, 1'b0, 8'h10, 8'h00, 1'b0, "pre_rd_10");
        @(negedge clk);
        req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 8'h10; din_s[0] = 8'hAA;
        @(posedge clk); #1;
        req_s[0] = 1'b0; wr_s[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (dout_s[0] !== 8'h00 || rdy_s[0] !== 1'b0 || bsy_s[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort reset: dout %h ready %b busy %b want 00 0 0",
                     dout_s[0], rdy_s[0], bsy_s[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (rdy_s[0] !== 1'b0) begin
                fails++;
                $display("FAIL abort stray ready: got %b want 0 (cycle %0d)", rdy_s[0], i);
            end
        end
        access(0, 1'b0, 8'h10, 8'h00, 1'b0, "post_rd_10");
    endtask

    task automatic test_zero_wait;
        bit got;
        bit want;
        access(1, 1'b1, 8'h20, 8'h5A, 1'b0, "zw_wr_20");
        access(1, 1'b0, 8'h20, 8'h00, 1'b0, "zw_rd_20");
        for (int j = 0; j < 3; j++) push_exp(1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        req_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 8'h20;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            got  = rdy_s[1];
            want = (i % 3) == 1;
            tests_run++;
            if (got !== want) begin
                fails++;
                $display("FAIL zw_stream ready idx %0d: got %b want %b", i, got, want);
            end
            if (got) check_pop(1, "zw_stream");
        end
        req_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        while (sb.size() > 0) begin
            tests_run++; fails++;
            $display("FAIL zw_stream missing ready: got 0 want 1");
            void'(sb.pop_front());
        end
    endtask

    task automatic test_stability;
        access(0, 1'b1, 8'h06, 8'h77, 1'b0, "st_wr_06");
        access(0, 1'b0, 8'h05, 8'h00, 1'b1, "st_rd_05");
        access(0, 1'b0, 8'h06, 8'h00, 1'b0, "st_rd_06");
    endtask

    task automatic test_out_of_range;
        access(2, 1'b1, 8'h7F, 8'h12, 1'b0, "oor_wr_7f");
        access(2, 1'b1, 8'h80, 8'hFF, 1'b0, "oor_wr_80");
        access(2, 1'b0, 8'h7F, 8'h00, 1'b0, "oor_rd_7f");
        access(2, 1'b0, 8'h80, 8'h00, 1'b0, "oor_rd_80");
        access(2, 1'b0, 8'h00, 8'h00, 1'b0, "oor_rd_00_after");
    endtask

    task automatic test_back_to_back;
        access(0, 1'b1, 8'h01, 8'h11, 1'b0, "b2b_wr_01");
        access(0, 1'b1, 8'h02, 8'h22, 1'b0, "b2b_wr_02");
        access(0, 1'b0, 8'h01, 8'h00, 1'b0, "b2b_rd_01");
        access(0, 1'b0, 8'h02, 8'h00, 1'b0, "b2b_rd_02");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            addr_s[d] = 8'h00; din_s[d] = 8'h00;
            wr_s[d] = 1'b0; req_s[d] = 1'b0;
        end
        ref_mem[2][0] = 8'h00;
        test_reset;
        access(2, 1'b1, 8'h00, 8'h00, 1'b0, "init_wr_00");
        test_write_read;
        test_abort_reset;
        test_zero_wait;
        test_stability;
        test_out_of_range;
        test_back_to_back;
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
